interface_hcsr04_bcd: RTL and testbench
=======================================

# interface_hcsr04_bcd

Single-channel HC-SR04 ultrasonic ranging front end. On a measurement request it drives the trigger pulse, times the returned echo pulse and converts its width to centimetres as three packed BCD digits, hundreds in bits [11:8] down to units in [3:0]. The BCD format lets the downstream ASCII stage add 0x30 per nibble directly. Three instances feed the averaging/classification stage, one per sensor. The block also detects a missing or overlong echo and reports it as a timeout.

## Interface
Parameters:
- CICLOS_TRIGGER, 500: trigger high time in clocks (10 µs at 50 MHz).
- CICLOS_POR_CM, 2941: clocks of echo-high per centimetre (58.82 µs at 50 MHz).
- CICLOS_TIMEOUT, 1_500_000: maximum clocks from trigger end to echo fall (30 ms).

Ports (name, direction, width, meaning):
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- zera  in  1  synchronous clear; same effect as reset, applied on the next edge.
- medir  in  1  measurement request, sampled only in INICIAL.
- echo  in  1  raw sensor echo, asynchronous; passed through a 2-flop synchronizer internally.
- trigger  out  1  registered trigger to the sensor.
- medida  out  12  last result in BCD cm, held until the next result.
- pronto  out  1  one-cycle pulse when medida/timeout are updated.
- timeout  out  1  level, valid from pronto; 1 when the last measurement timed out.
- ocupado  out  1  high in every state except INICIAL.
- db_estado  out  4  current FSM state code.

## Operation
- FSM states and transitions:
  - INICIAL (0): stays until medir=1, then goes to PREPARA.
  - PREPARA (1): clears the prescaler, BCD counter, trigger counter and timeout counter, then goes to ENVIA_TRIGGER.
  - ENVIA_TRIGGER (2): trigger=1 for exactly CICLOS_TRIGGER cycles, then goes to ESPERA_ECHO.
  - ESPERA_ECHO (3): waits for a rising edge of synchronized echo, then goes to MEDINDO. A level that is already high does not count as an edge.
  - MEDINDO (4): prescaler counts 0..CICLOS_POR_CM-1. Each wrap increments the BCD counter by one, with decimal carry units→tens→hundreds. When synchronized echo falls, go to ARMAZENA.
  - ARMAZENA (5): loads medida from the BCD counter, sets timeout=0, then goes to FINAL.
  - TIMEOUT (6): loads medida=12'h999, sets timeout=1, then goes to FINAL.
  - FINAL (7): pronto=1 for this one cycle, then goes to INICIAL.
- Timeout counter runs in ESPERA_ECHO and MEDINDO. When it reaches CICLOS_TIMEOUT-1, go to TIMEOUT. If the echo fall and the timeout occur on the same cycle, the echo fall wins.
- BCD counter saturates at 999 and does not wrap to 000.
- Any fractional centimetre is truncated. Echo widths shorter than CICLOS_POR_CM give 000.
- medir is ignored while ocupado=1; no request is queued.
- Counter widths are $clog2 of the respective parameter.

## Timing
- Reset or zera sets: state=INICIAL, trigger=0, medida=12'h000, pronto=0, timeout=0, ocupado=0, db_estado=0, both synchronizer flops=0.
- medir high at edge k (in INICIAL) gives PREPARA at k+1. trigger rises at k+2 and is high for edges k+2..k+1+CICLOS_TRIGGER.
- Echo sync latency is 2 clocks, so the measurement window equals the raw echo width ±1 clock.
- Echo fall seen at edge e gives ARMAZENA at e+1 and pronto at e+2.
- Total request-to-pronto latency = 3 + CICLOS_TRIGGER + wait + echo width + 4 clocks, approximately.
- Asynchronous reset mid-measurement aborts immediately: trigger drops in the same cycle and no pronto is produced.

## Test plan
Parameters for all scenarios: CICLOS_TRIGGER=4, CICLOS_POR_CM=10, CICLOS_TIMEOUT=2000.
- Assert reset low with echo=1 → all outputs 0, db_estado=0. After release, no activity until medir.
- One-cycle medir; echo rises 20 cycles after trigger falls and stays high 125 cycles → trigger high exactly 4 cycles; medida=12'h012; timeout=0; pronto exactly 1 cycle; ocupado falls the cycle after pronto.
- medir; echo never rises → pronto 2000 (±3) cycles after trigger fall; medida=12'h999; timeout=1. A following normal 57-cycle echo → medida=12'h005, timeout=0.
- CICLOS_TIMEOUT=20000; echo high 10050 cycles → medida=12'h999 (saturated), timeout=0. Echo high 1000 cycles → medida=12'h100, checking carry through tens into hundreds.
- Echo held high before and through the trigger → no measurement starts; the timeout path is taken, giving medida=12'h999, timeout=1.
- medir pulsed repeatedly during MEDINDO → result unaffected and exactly one pronto. reset low mid-MEDINDO → trigger=0, medida=0, no pronto. zera mid-measurement → same as reset, applied one edge later.

Source files
------------

// File: rtl/interface_hcsr04_bcd.sv
// HC-SR04 ranging front end: issues the trigger pulse, times the echo and
// reports the distance as three packed BCD digits, flagging missing/overlong echoes.
module interface_hcsr04_bcd #(
    parameter int CICLOS_TRIGGER = 500,
    parameter int CICLOS_POR_CM  = 2941,
    parameter int CICLOS_TIMEOUT = 1_500_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        zera,
    input  logic        medir,
    input  logic        echo,
    output logic        trigger,
    output logic [11:0] medida,
    output logic        pronto,
    output logic        timeout,
    output logic        ocupado,
    output logic [3:0]  db_estado
);

    // state          | meaning
    // INICIAL        | idle, waiting for medir
    // PREPARA        | clear prescaler, BCD, trigger and timeout counters
    // ENVIA_TRIGGER  | trigger high for CICLOS_TRIGGER cycles
    // ESPERA_ECHO    | wait for rising edge of synchronized echo
    // MEDINDO        | echo high, accumulate centimetres in BCD
    // ARMAZENA       | publish BCD count, timeout=0
    // TIMEOUT        | publish 999, timeout=1
    // FINAL          | pronto pulse, back to idle
    typedef enum logic [3:0] {
        INICIAL       = 4'd0,
        PREPARA       = 4'd1,
        ENVIA_TRIGGER = 4'd2,
        ESPERA_ECHO   = 4'd3,
        MEDINDO       = 4'd4,
        ARMAZENA      = 4'd5,
        TIMEOUT       = 4'd6,
        FINAL         = 4'd7
    } estado_t;

    localparam int TRIG_W  = $clog2(CICLOS_TRIGGER);
    localparam int PRESC_W = $clog2(CICLOS_POR_CM);
    localparam int TMO_W   = $clog2(CICLOS_TIMEOUT);

    localparam logic [TRIG_W-1:0]  TRIG_LAST  = TRIG_W'(CICLOS_TRIGGER - 1);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CICLOS_POR_CM - 1);
    localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(CICLOS_TIMEOUT - 1);

    estado_t             estado;
    logic                echo_s1;
    logic                echo_s2;
    logic                echo_d;
    logic                echo_rise;
    logic                echo_fall;
    logic [TRIG_W-1:0]   trig_cnt;
    logic [PRESC_W-1:0]  presc;
    logic [TMO_W-1:0]    tmo_cnt;
    logic [11:0]         bcd;

    // Decimal increment with carry units->tens->hundreds, sticking at 999.
    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (v != 12'h999) begin
            if (v[3:0] != 4'd9) begin
                r[3:0] = v[3:0] + 4'd1;
            end else begin
                r[3:0] = 4'd0;
                if (v[7:4] != 4'd9) begin
                    r[7:4] = v[7:4] + 4'd1;
                end else begin
                    r[7:4]  = 4'd0;
                    r[11:8] = v[11:8] + 4'd1;
                end
            end
        end
        return r;
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            echo_s1 <= 1'b0;
            echo_s2 <= 1'b0;
        end else if (zera) begin
            echo_s1 <= 1'b0;
            echo_s2 <= 1'b0;
        end else begin
            echo_s1 <= echo;
            echo_s2 <= echo_s1;
        end
    end

    // echo_d tracks the previous synchronized level, so an echo already high
    // on entry to ESPERA_ECHO never produces a rise.
    assign echo_rise = echo_s2 & ~echo_d;
    assign echo_fall = ~echo_s2 & echo_d;
    assign db_estado = estado;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado   <= INICIAL;
            trigger  <= 1'b0;
            medida   <= 12'h000;
            pronto   <= 1'b0;
            timeout  <= 1'b0;
            ocupado  <= 1'b0;
            echo_d   <= 1'b0;
            trig_cnt <= '0;
            presc    <= '0;
            tmo_cnt  <= '0;
            bcd      <= 12'h000;
        end else if (zera) begin
            estado   <= INICIAL;
            trigger  <= 1'b0;
            medida   <= 12'h000;
            pronto   <= 1'b0;
            timeout  <= 1'b0;
            ocupado  <= 1'b0;
            echo_d   <= 1'b0;
            trig_cnt <= '0;
            presc    <= '0;
            tmo_cnt  <= '0;
            bcd      <= 12'h000;
        end else begin
            echo_d <= echo_s2;
            pronto <= 1'b0;
            case (estado)
                INICIAL: begin
                    if (medir) begin
                        estado  <= PREPARA;
                        ocupado <= 1'b1;
                    end
                end
                PREPARA: begin
                    presc    <= '0;
                    bcd      <= 12'h000;
                    trig_cnt <= '0;
                    tmo_cnt  <= '0;
                    trigger  <= 1'b1;
                    estado   <= ENVIA_TRIGGER;
                end
                ENVIA_TRIGGER: begin
                    if (trig_cnt == TRIG_LAST) begin
                        trigger <= 1'b0;
                        estado  <= ESPERA_ECHO;
                    end else begin
                        trig_cnt <= trig_cnt + 1'b1;
                    end
                end
                ESPERA_ECHO: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (tmo_cnt == TMO_LAST) begin
                        estado <= TIMEOUT;
                    end else if (echo_rise) begin
                        estado <= MEDINDO;
                    end
                end
                MEDINDO: begin
                    // The fall cycle still counts, so the window spans the full raw width.
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (presc == PRESC_LAST) begin
                        presc <= '0;
                        bcd   <= bcd_inc(bcd);
                    end else begin
                        presc <= presc + 1'b1;
                    end
                    if (echo_fall) begin
                        estado <= ARMAZENA;
                    end else if (tmo_cnt == TMO_LAST) begin
                        estado <= TIMEOUT;
                    end
                end
                ARMAZENA: begin
                    medida  <= bcd;
                    timeout <= 1'b0;
                    pronto  <= 1'b1;
                    estado  <= FINAL;
                end
                TIMEOUT: begin
                    medida  <= 12'h999;
                    timeout <= 1'b1;
                    pronto  <= 1'b1;
                    estado  <= FINAL;
                end
                FINAL: begin
                    ocupado <= 1'b0;
                    estado  <= INICIAL;
                end
                default: begin
                    trigger <= 1'b0;
                    ocupado <= 1'b0;
                    estado  <= INICIAL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interface_hcsr04_bcd.sv
// Bench for interface_hcsr04_bcd: two instances (short and long timeout) share
// stimulus; results are predicted from echo width and timing with plain arithmetic.
module tb_interface_hcsr04_bcd;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        zera  = 1'b0;
    logic        medir = 1'b0;
    logic        echo  = 1'b1;

    logic        trigger_a, pronto_a, timeout_a, ocupado_a;
    logic [11:0] medida_a;
    logic [3:0]  db_estado_a;
    logic        trigger_b, pronto_b, timeout_b, ocupado_b;
    logic [11:0] medida_b;
    logic [3:0]  db_estado_b;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    interface_hcsr04_bcd #(
        .CICLOS_TRIGGER(4), .CICLOS_POR_CM(10), .CICLOS_TIMEOUT(2000)
    ) dut_a (
        .clock(clock), .reset(reset), .zera(zera), .medir(medir), .echo(echo),
        .trigger(trigger_a), .medida(medida_a), .pronto(pronto_a),
        .timeout(timeout_a), .ocupado(ocupado_a), .db_estado(db_estado_a)
    );

    interface_hcsr04_bcd #(
        .CICLOS_TRIGGER(4), .CICLOS_POR_CM(10), .CICLOS_TIMEOUT(20000)
    ) dut_b (
        .clock(clock), .reset(reset), .zera(zera), .medir(medir), .echo(echo),
        .trigger(trigger_b), .medida(medida_b), .pronto(pronto_b),
        .timeout(timeout_b), .ocupado(ocupado_b), .db_estado(db_estado_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Observed activity, sampled on the falling edge.
    int          cyc = 0;
    int          np_a = 0, np_b = 0, trig_hi_a = 0, trig_hi_b = 0;
    int          fall_cyc_a = 0, pronto_cyc_a = 0;
    logic [11:0] res_a = '0, res_b = '0;
    logic        tmo_a = 1'b0, tmo_b = 1'b0;
    logic        trig_prev_a = 1'b0, pr_prev_a = 1'b0, ocup_after_a = 1'b1;

    always @(negedge clock) begin
        cyc++;
        if (trigger_a) trig_hi_a++;
        if (trigger_b) trig_hi_b++;
        if (trig_prev_a && !trigger_a) fall_cyc_a = cyc;
        if (pr_prev_a) ocup_after_a = ocupado_a;
        if (pronto_a) begin
            np_a++; res_a = medida_a; tmo_a = timeout_a; pronto_cyc_a = cyc;
        end
        if (pronto_b) begin
            np_b++; res_b = medida_b; tmo_b = timeout_b;
        end
        trig_prev_a = trigger_a;
        pr_prev_a   = pronto_a;
    end

    // {timeout, medida}: whole centimetres of echo width, capped at 999, or
    // 999/timeout when the echo never starts or ends past the limit.
    function automatic logic [12:0] model(input int ct, input int delay, input int width,
                                          input bit pre_high);
        int cm;
        if (pre_high || width == 0 || delay + width + 3 >= ct) return {1'b1, 12'h999};
        cm = width / 10;
        if (cm > 999) cm = 999;
        return {1'b0, 4'(cm / 100), 4'((cm / 10) % 10), 4'(cm % 10)};
    endfunction

    task automatic start_and_wait_trigger();
        int n;
        np_a = 0; np_b = 0; trig_hi_a = 0; trig_hi_b = 0;
        @(negedge clock) medir = 1'b1;
        @(negedge clock) medir = 1'b0;
        n = 0;
        while (!trigger_a && n < 20) begin @(negedge clock); n++; end
        n = 0;
        while (trigger_a && n < 20) begin @(negedge clock); n++; end
    endtask

    task automatic run(input string tag, input int delay, input int width,
                       input bit pre_high, input bit poke);
        logic [12:0] ea, eb;
        int n;
        ea = model(2000, delay, width, pre_high);
        eb = model(20000, delay, width, pre_high);
        if (pre_high) echo = 1'b1;
        start_and_wait_trigger();
        if (!pre_high && width > 0) begin
            repeat (delay) @(negedge clock);
            echo = 1'b1;
            for (int i = 0; i < width; i++) begin
                if (poke) medir = ((i % 7) == 3);
                @(negedge clock);
            end
            medir = 1'b0;
            echo  = 1'b0;
        end
        n = 0;
        while ((ocupado_a || ocupado_b) && n < 25000) begin @(negedge clock); n++; end
        if (n >= 25000) check_eq({tag, "_hang"}, 1, 0);
        echo = 1'b0;
        repeat (3) @(negedge clock);
        check_eq({tag, "_trig_a"}, trig_hi_a, 4);
        check_eq({tag, "_trig_b"}, trig_hi_b, 4);
        check_eq({tag, "_npronto_a"}, np_a, 1);
        check_eq({tag, "_npronto_b"}, np_b, 1);
        check_eq({tag, "_medida_a"}, res_a, ea[11:0]);
        check_eq({tag, "_timeout_a"}, tmo_a, ea[12]);
        check_eq({tag, "_medida_b"}, res_b, eb[11:0]);
        check_eq({tag, "_timeout_b"}, tmo_b, eb[12]);
    endtask

    initial begin
        int d, w;
        // reset held with echo high
        repeat (3) @(negedge clock);
        check_eq("rst_trigger", trigger_a, 0);
        check_eq("rst_medida", medida_a, 0);
        check_eq("rst_pronto", pronto_a, 0);
        check_eq("rst_timeout", timeout_a, 0);
        check_eq("rst_ocupado", ocupado_a, 0);
        check_eq("rst_estado", db_estado_a, 0);
        check_eq("rst_estado_b", db_estado_b, 0);
        reset = 1'b1;
        echo  = 1'b0;
        repeat (20) @(negedge clock);
        check_eq("idle_ocupado", ocupado_a, 0);
        check_eq("idle_estado", db_estado_a, 0);
        check_eq("idle_pronto", np_a, 0);

        run("basic125", 20, 125, 1'b0, 1'b0);
        check_eq("ocup_after_pronto", ocup_after_a, 0);
        run("noecho", 0, 0, 1'b0, 1'b0);
        check_eq("tmo_latency", ((pronto_cyc_a - fall_cyc_a) >= 1997 &&
                                 (pronto_cyc_a - fall_cyc_a) <= 2003), 1);
        run("w57", 10, 57, 1'b0, 1'b0);
        run("sat", 20, 10050, 1'b0, 1'b0);
        run("w1000", 20, 1000, 1'b0, 1'b0);
        run("prehigh", 0, 0, 1'b1, 1'b0);
        run("poke", 15, 300, 1'b0, 1'b1);
        run("w9", 5, 9, 1'b0, 1'b0);
        run("w10", 5, 10, 1'b0, 1'b0);

        // async reset mid-measurement
        start_and_wait_trigger();
        repeat (10) @(negedge clock);
        echo = 1'b1;
        repeat (50) @(negedge clock);
        reset = 1'b0;
        #1;
        check_eq("amid_trigger", trigger_a, 0);
        check_eq("amid_medida", medida_a, 0);
        check_eq("amid_ocupado", ocupado_a, 0);
        check_eq("amid_estado", db_estado_a, 0);
        @(negedge clock);
        reset = 1'b1;
        echo  = 1'b0;
        repeat (100) @(negedge clock);
        check_eq("amid_npronto", np_a, 0);

        run("again125", 8, 125, 1'b0, 1'b0);

        // synchronous clear mid-measurement
        start_and_wait_trigger();
        repeat (10) @(negedge clock);
        echo = 1'b1;
        repeat (50) @(negedge clock);
        zera = 1'b1;
        #1;
        check_eq("zera_pending_ocupado", ocupado_a, 1);
        check_eq("zera_pending_medida", medida_a, 12'h012);
        @(negedge clock);
        zera = 1'b0;
        check_eq("zera_ocupado", ocupado_a, 0);
        check_eq("zera_medida", medida_a, 0);
        check_eq("zera_estado", db_estado_b, 0);
        echo = 1'b0;
        repeat (100) @(negedge clock);
        check_eq("zera_npronto", np_a + np_b, 0);

        for (int k = 0; k < 8; k++) begin
            d = $urandom_range(40, 2);
            w = $urandom_range(2500, 1);
            if ((d + w + 3) > 1980 && (d + w + 3) < 2020) w = w + 60;
            run($sformatf("rnd%0d", k), d, w, 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
